// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: instruction width, opcodes, fetch FSM states
package cpu_pkg;

   localparam int INST_W = 32;

   // Full 11-bit opcodes, inst[31:21]
   localparam logic [10:0] OP_LDUR = 11'h7C2;
   localparam logic [10:0] OP_STUR = 11'h7C0;
   localparam logic [10:0] OP_ADD  = 11'h458;
   localparam logic [10:0] OP_SUB  = 11'h658;
   localparam logic [10:0] OP_AND  = 11'h450;
   localparam logic [10:0] OP_ORR  = 11'h550;
   localparam logic [10:0] OP_HALT = 11'h7FF;

   // Prefix opcodes, matched against the top bits of inst
   localparam logic [9:0]  OP_ADDI = 10'h244;
   localparam logic [7:0]  OP_CBZ  = 8'hB4;
   localparam logic [7:0]  OP_CBNZ = 8'hB5;
   localparam logic [5:0]  OP_B    = 6'h05;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      HOLD,
      FLUSH,
      HALTED
   } fetch_state_t;

   function automatic logic is_halt(input logic [10:0] opc);
      return opc == OP_HALT;
   endfunction

endpackage

// File: rtl/cpu_fetch_skid.sv
// rtl/cpu_fetch_skid.sv - 1-entry instruction/pc buffer with stream handshakes on both sides
module cpu_fetch_skid
   import cpu_pkg::*;
#(
   parameter int PC_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              s_tvalid,
   output logic              s_tready,
   input  logic [INST_W-1:0] s_tdata,
   input  logic [PC_W-1:0]   s_tpc,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic [INST_W-1:0] m_tdata,
   output logic [PC_W-1:0]   m_tpc
);

   logic              valid_q, valid_d;
   logic [INST_W-1:0] data_q, data_d;
   logic [PC_W-1:0]   pc_q, pc_d;

   // Strictly one entry: no push while occupied, so the fetch side never overruns it
   assign s_tready = !valid_q;
   assign m_tvalid = valid_q;
   assign m_tdata  = data_q;
   assign m_tpc    = pc_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      pc_d    = pc_q;
      if (m_tready) begin
         valid_d = 1'b0;
      end
      if (s_tvalid && s_tready) begin
         valid_d = 1'b1;
         data_d  = s_tdata;
         pc_d    = s_tpc;
      end
      if (flush) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
      end
   end

endmodule

// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - fetch stage: PC, imem req/ack, decode valid/ready, redirects, HALT
// FETCH_SKID_EN: fetch pc+4 while holding an instruction, parked in cpu_fetch_skid.
module cpu_fetch
   import cpu_pkg::*;
#(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     inst,
   output logic [PC_W-1:0] inst_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   input  logic            redir_valid,
   input  logic [PC_W-1:0] redir_pc,
   input  logic [PC_W-1:0] redir_imm,
   output logic            halted
);

   fetch_state_t      state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   addr_q, addr_d;
   logic [PC_W-1:0]   inst_pc_q, inst_pc_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic [PC_W-1:0]   redir_sum, redir_tgt;
   logic              accept, hold_req;

   assign redir_sum = redir_pc + (redir_imm << 2);
   assign redir_tgt = {redir_sum[PC_W-1:2], 2'b00};
   assign accept    = (state_q == HOLD) && inst_ready;

`ifdef FETCH_SKID_EN
   logic              skid_push, skid_pop, skid_flush;
   logic              skid_valid, skid_in_ready;
   logic [INST_W-1:0] skid_data;
   logic [PC_W-1:0]   skid_pc;

   // No prefetch behind a HALT, so a halting fetch never has data in flight
   assign hold_req = (state_q == HOLD) && skid_in_ready && !is_halt(inst_q[31:21]);

   cpu_fetch_skid #(.PC_W(PC_W)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .flush    (skid_flush),
      .s_tvalid (skid_push),
      .s_tready (skid_in_ready),
      .s_tdata  (imem_rdata),
      .s_tpc    (pc_q),
      .m_tvalid (skid_valid),
      .m_tready (skid_pop),
      .m_tdata  (skid_data),
      .m_tpc    (skid_pc)
   );
`else
   assign hold_req = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      imem_req  = 1'b0;
`ifdef FETCH_SKID_EN
      skid_push  = 1'b0;
      skid_pop   = 1'b0;
      skid_flush = 1'b0;
`endif
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            imem_req = 1'b1;
            if (redir_valid) begin
               pc_d    = redir_tgt;
               state_d = imem_ack ? REQ : FLUSH;
            end else if (imem_ack) begin
               inst_d    = imem_rdata;
               inst_pc_d = pc_q;
               pc_d      = pc_q + PC_W'(4);
               state_d   = HOLD;
            end
         end
         HOLD: begin
            imem_req = hold_req;
            if (redir_valid) begin
               pc_d    = redir_tgt;
               state_d = (hold_req && !imem_ack) ? FLUSH : REQ;
`ifdef FETCH_SKID_EN
               skid_flush = 1'b1;
`endif
            end else if (accept) begin
               state_d = is_halt(inst_q[31:21]) ? HALTED : REQ;
`ifdef FETCH_SKID_EN
               if (!is_halt(inst_q[31:21]) && skid_valid) begin
                  skid_pop  = 1'b1;
                  inst_d    = skid_data;
                  inst_pc_d = skid_pc;
                  state_d   = HOLD;
               end else if (hold_req && imem_ack) begin
                  inst_d    = imem_rdata;
                  inst_pc_d = pc_q;
                  pc_d      = pc_q + PC_W'(4);
                  state_d   = HOLD;
               end
`endif
            end
`ifdef FETCH_SKID_EN
            else if (hold_req && imem_ack) begin
               skid_push = 1'b1;
               pc_d      = pc_q + PC_W'(4);
            end
`endif
         end
         FLUSH: begin
            imem_req = 1'b1;
            if (redir_valid) begin
               pc_d = redir_tgt;
            end
            if (imem_ack) begin
               state_d = REQ;
            end
         end
         HALTED: ;
         default: ;
      endcase
      // FLUSH keeps presenting the abandoned address until its ack drains
      addr_d = (state_d == FLUSH) ? addr_q : pc_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         inst_q    <= '0;
         inst_pc_q <= RESET_PC;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   assign imem_addr  = addr_q;
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = (state_q == HOLD);
   assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - randomized bench for cpu_fetch against a transaction-level fetch model
module tb_cpu_fetch;

   localparam int              PC_W     = 64;
   localparam logic [PC_W-1:0] RESET_PC = '0;
`ifdef FETCH_SKID_EN
   localparam int TPUT = 20;
`else
   localparam int TPUT = 10;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_ack = 1'b0;
   logic [31:0]     imem_rdata = '0;
   logic [31:0]     inst;
   logic [PC_W-1:0] inst_pc;
   logic            inst_valid;
   logic            inst_ready = 1'b0;
   logic            redir_valid = 1'b0;
   logic [PC_W-1:0] redir_pc = '0;
   logic [PC_W-1:0] redir_imm = '0;
   logic            halted;

   cpu_fetch #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .redir_valid (redir_valid),
      .redir_pc    (redir_pc),
      .redir_imm   (redir_imm),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem [64];

   int max_lat, p_ready, p_redir;
   bit redir_on_halt, hr_fired;

   logic [PC_W-1:0] exp_pc;
   bit              exp_halted;
   int              since_rst;

   bit busy;
   int lat, waited;

   bit              prev_pend, prev_hold;
   logic [PC_W-1:0] prev_addr, prev_ipc;
   logic [31:0]     prev_inst;
   int              valid_cnt;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      inst_ready  = 1'b1;
      redir_valid = 1'b1;
      redir_pc    = 64'h80;
      redir_imm   = 64'h4;
      imem_ack    = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_req", imem_req, 0);
      check("rst_addr", imem_addr, RESET_PC);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, RESET_PC);
      check("rst_valid", inst_valid, 0);
      check("rst_halted", halted, 0);
      rst         = 1'b0;
      redir_valid = 1'b0;
      imem_ack    = 1'b0;
      exp_pc      = RESET_PC;
      exp_halted  = 1'b0;
      since_rst   = 0;
      busy        = 1'b0;
      prev_pend   = 1'b0;
      prev_hold   = 1'b0;
   endtask

   // One clock cycle, entered and left at a falling edge
   task automatic step();
      logic [31:0]     w;
      logic [PC_W-1:0] tgt;
      bit              was_halted;
      int              v;

      if (prev_pend) begin
         check("req_held", imem_req, 1);
         check("addr_held", imem_addr, prev_addr);
      end
      if (prev_hold) begin
         check("inst_held_valid", inst_valid, 1);
         check("inst_held", inst, prev_inst);
         check("inst_pc_held", inst_pc, prev_ipc);
      end
      if (imem_req) check("addr_align", imem_addr[1:0], 0);
      check("halted", halted, exp_halted);
      if (exp_halted) begin
         check("halt_no_req", imem_req, 0);
         check("halt_no_valid", inst_valid, 0);
      end
      if (inst_valid) begin
         valid_cnt++;
         check("inst_pc", inst_pc, exp_pc);
         check("inst", inst, mem[exp_pc[7:2]]);
      end

      inst_ready  = ($urandom_range(99) < p_ready);
      redir_valid = ($urandom_range(99) < p_redir);
      if (redir_valid) begin
         if ($urandom_range(7) == 0) redir_pc = {56'hFFFFFFFFFFFFFF, 8'($urandom)};
         else                        redir_pc = 64'($urandom_range(255));
         v         = int'($urandom_range(16)) - 8;
         redir_imm = longint'(v);
      end
      if (redir_on_halt && inst_valid && inst[31:21] == 11'h7FF) begin
         inst_ready  = 1'b1;
         redir_valid = 1'b1;
         redir_pc    = 64'h40;
         redir_imm   = '0;
         hr_fired    = 1'b1;
      end

      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (rst || !imem_req) begin
         busy = 1'b0;
      end else begin
         if (!busy) begin
            busy   = 1'b1;
            lat    = $urandom_range(max_lat);
            waited = 0;
         end
         if (waited == lat) begin
            imem_ack   = 1'b1;
            imem_rdata = mem[imem_addr[7:2]];
            busy       = 1'b0;
         end else begin
            waited++;
         end
      end

      prev_pend = imem_req && !imem_ack && !rst;
      prev_addr = imem_addr;
      prev_hold = inst_valid && !inst_ready && !redir_valid && !rst;
      prev_inst = inst;
      prev_ipc  = inst_pc;

      if (rst) begin
         exp_pc     = RESET_PC;
         exp_halted = 1'b0;
         since_rst  = 0;
      end else begin
         was_halted = exp_halted;
         if (inst_valid && inst_ready) begin
            w = mem[exp_pc[7:2]];
            if (w[31:21] == 11'h7FF && !redir_valid) exp_halted = 1'b1;
            exp_pc = exp_pc + 64'd4;
         end
         if (redir_valid && !was_halted && since_rst >= 1) begin
            tgt      = redir_pc + redir_imm * 64'd4;
            tgt[1:0] = 2'b00;
            exp_pc   = tgt;
         end
         since_rst++;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 64; i++) begin
         w = $urandom;
         if (w[31:21] == 11'h7FF) w[31] = 1'b0;
         mem[i] = w;
      end
      max_lat       = 0;
      p_ready       = 100;
      p_redir       = 0;
      redir_on_halt = 1'b0;
      hr_fired      = 1'b0;
      valid_cnt     = 0;
      @(negedge clk);

      // Zero-wait, always ready: first request and sustained rate
      do_reset();
      for (int i = 0; i < 4 && !imem_req; i++) step();
      check("first_req", imem_req, 1);
      check("first_addr", imem_addr, RESET_PC);
      for (int i = 0; i < 6 && !inst_valid; i++) step();
      check("first_valid", inst_valid, 1);
      valid_cnt = 0;
      repeat (20) step();
      check("throughput", valid_cnt, TPUT);

      // HALT at 0xC: stop, ignore redirects, recover on reset
      mem[3] = 32'hFFE00000;
      do_reset();
      for (int i = 0; i < 30 && !halted; i++) step();
      check("halt_reached", halted, 1);
      p_redir = 50;
      repeat (20) step();
      p_redir = 0;
      do_reset();
      repeat (8) step();

      // HALT accepted together with a redirect to 0x40
      do_reset();
      redir_on_halt = 1'b1;
      for (int i = 0; i < 30 && !hr_fired; i++) step();
      check("hr_fired", hr_fired, 1);
      check("hr_halted", halted, 0);
      check("hr_req", imem_req, 1);
      check("hr_addr", imem_addr, 64'h40);
      redir_on_halt = 1'b0;
      repeat (10) step();

      // Random latency, backpressure, redirects, one HALT word in the image
      mem[3]  = 32'h8B020020;
      mem[45] = 32'hFFE00000;
      for (int r = 0; r < 8; r++) begin
         max_lat = r % 4;
         p_ready = (r % 2 == 1) ? 100 : 55;
         p_redir = (r < 4) ? 6 : 15;
         do_reset();
         repeat (300) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
